// File: rtl/ikaopm_multi_acc.sv
// ikaopm_multi_acc: per-channel slot accumulator with 16-bit saturation and a
// serial output stream (linear or 13-bit floating words).
module ikaopm_multi_acc #(
    parameter int CH    = 2,
    parameter int IW    = 14,
    parameter int AW    = 18,
    parameter int FLOAT = 1
) (
    input  logic              i_EMUCLK,
    input  logic              i_MRST,
    input  logic              i_phi1_NCEN_n,
    input  logic              i_SLOT_VALID,
    input  logic [IW-1:0]     i_SLOT_DATA,
    input  logic [CH-1:0]     i_SLOT_CHMASK,
    input  logic              i_FRAME_END,
    input  logic              i_SAT_CLR,
    output logic [CH*16-1:0]  o_EMU_PCM,
    output logic              o_EMU_VALID,
    output logic              o_SO,
    output logic              o_SH,
    output logic [CH-1:0]     o_SAT,
    output logic              o_OVR
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;
    logic [CH-1:0][AW-1:0] acc, sum;
    logic [CH-1:0][15:0] sat_val, sreg, pcm_nxt;
    logic [CH-1:0] clamp;
    logic [3:0] bit_idx;
    logic [2:0] ch_idx;
    logic pending, en, fe, last, restart;
    logic [15:0] lin, word;

    // Floating word: 9 mantissa bits from a tap chosen by leading-bit position,
    // sign bit, then 3-bit exponent (tap+1).
    function automatic logic [15:0] flt(input logic [15:0] s);
        logic [15:0] u;
        logic [5:0] m;
        logic [2:0] tap;
        u   = {~s[15], s[14:0]};
        m   = u[15] ? u[14:9] : ~u[14:9];
        tap = m[5] ? 3'd6 : m[4] ? 3'd5 : m[3] ? 3'd4 : m[2] ? 3'd3 : m[1] ? 3'd2 : m[0] ? 3'd1 : 3'd0;
        return {3'b000, tap + 3'd1, u[15], u[tap +: 9]};
    endfunction

    always_comb begin
        en      = ~i_phi1_NCEN_n;
        fe      = en & i_FRAME_END;
        sum     = '0;
        clamp   = '0;
        sat_val = '0;
        lin     = '0;
        for (int n = 0; n < CH; n++) begin
            sum[n]     = acc[n] + ((i_SLOT_VALID && i_SLOT_CHMASK[n]) ? AW'($signed(i_SLOT_DATA)) : '0);
            clamp[n]   = sum[n][AW-1:15] != {(AW-15){sum[n][AW-1]}};
            sat_val[n] = clamp[n] ? (sum[n][AW-1] ? 16'h8000 : 16'h7fff) : sum[n][15:0];
            if (ch_idx == 3'(n)) lin = sreg[n];
        end
        pcm_nxt   = fe ? sat_val : o_EMU_PCM;
        word      = (FLOAT != 0) ? flt(lin) : lin;
        last      = bit_idx == 4'd15 && ch_idx == 3'(CH - 1);
        restart   = pending | fe;
        state_nxt = state;
        if (state == IDLE && fe) state_nxt = SHIFT;
        else if (state == SHIFT && last && !restart) state_nxt = IDLE;
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            state       <= IDLE;
            acc         <= '0;
            sreg        <= '0;
            o_EMU_PCM   <= '0;
            o_EMU_VALID <= 1'b0;
            o_SO        <= 1'b0;
            o_SH        <= 1'b0;
            o_SAT       <= '0;
            o_OVR       <= 1'b0;
            pending     <= 1'b0;
            bit_idx     <= '0;
            ch_idx      <= '0;
        end else begin
            o_EMU_VALID <= fe;
            if (en) begin
                state <= state_nxt;
                acc   <= fe ? '0 : sum;
                if (fe) o_EMU_PCM <= sat_val;
                o_SAT <= (fe ? clamp : '0) | (i_SAT_CLR ? '0 : o_SAT);
                if (state == SHIFT) begin
                    o_SO    <= word[bit_idx];
                    o_SH    <= bit_idx == 4'd0;
                    bit_idx <= bit_idx + 4'd1;
                    ch_idx  <= last ? 3'd0 : ch_idx + 3'(bit_idx == 4'd15);
                    pending <= last ? 1'b0 : restart;
                    if (fe) o_OVR <= 1'b1;
                    // A pending frame restarts the sequence with no idle gap.
                    if (last && restart) sreg <= pcm_nxt;
                end else begin
                    o_SO    <= 1'b0;
                    o_SH    <= 1'b0;
                    bit_idx <= '0;
                    ch_idx  <= '0;
                    if (fe) sreg <= sat_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_ikaopm_multi_acc.sv
// tb_ikaopm_multi_acc: directed checks of accumulation, saturation and both serial formats.
module tb_ikaopm_multi_acc;
    logic clk, rst, ncen, valid, fe, clr;
    logic signed [13:0] data;
    logic [1:0] mask;
    logic [31:0] pcm0, pcm1;
    logic vld0, vld1, so0, so1, sh0, sh1, ovr0, ovr1;
    logic [1:0] sat0, sat1;
    logic [15:0] wf[4], wl[4], shf[4], shl[4];
    logic v_after, any_sh;
    int checks = 0, errors = 0;

    ikaopm_multi_acc dut0 (
        .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_NCEN_n(ncen), .i_SLOT_VALID(valid),
        .i_SLOT_DATA(data), .i_SLOT_CHMASK(mask), .i_FRAME_END(fe), .i_SAT_CLR(clr),
        .o_EMU_PCM(pcm0), .o_EMU_VALID(vld0), .o_SO(so0), .o_SH(sh0), .o_SAT(sat0), .o_OVR(ovr0)
    );
    ikaopm_multi_acc #(.FLOAT(0)) dut1 (
        .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_NCEN_n(ncen), .i_SLOT_VALID(valid),
        .i_SLOT_DATA(data), .i_SLOT_CHMASK(mask), .i_FRAME_END(fe), .i_SAT_CLR(clr),
        .o_EMU_PCM(pcm1), .o_EMU_VALID(vld1), .o_SO(so1), .o_SH(sh1), .o_SAT(sat1), .o_OVR(ovr1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic signed [13:0] d, input logic [1:0] m, input logic f, input logic c);
        valid = 1; data = d; mask = m; fe = f; clr = c;
        step();
        valid = 0; data = 0; mask = 0; fe = 0; clr = 0;
    endtask

    task automatic frame(input logic signed [13:0] d, input logic [1:0] m, input int n, input logic c);
        for (int i = 0; i < n; i++) slot(d, m, i == n - 1, c && i == n - 1);
    endtask

    task automatic capture(input int nw, input int inj, input logic signed [13:0] d);
        for (int k = 0; k < 16 * nw; k++) begin
            if (k == inj) begin valid = 1; data = d; mask = 2'b11; fe = 1; end
            step();
            valid = 0; data = 0; mask = 0; fe = 0;
            if (k == 0) v_after = vld0 | vld1;
            wf[k/16][k%16] = so0; wl[k/16][k%16] = so1;
            shf[k/16][k%16] = sh0; shl[k/16][k%16] = sh1;
        end
    endtask

    task automatic chk_words(input string tag, input int nw, input logic [15:0] ef[4], input logic [15:0] el[4]);
        for (int w = 0; w < nw; w++) begin
            chk($sformatf("%s_flt%0d", tag, w), wf[w], ef[w]);
            chk($sformatf("%s_lin%0d", tag, w), wl[w], el[w]);
            chk($sformatf("%s_sh%0d", tag, w), {shf[w], shl[w]}, 32'h0001_0001);
        end
    endtask

    initial begin
        rst = 1; ncen = 0; valid = 0; data = 0; mask = 0; fe = 0; clr = 0;
        step(); step();
        chk("rst_pcm", pcm0 | pcm1, 0);
        chk("rst_out", {vld0, so0, sh0, sat0, ovr0, vld1, so1, sh1, sat1, ovr1}, 0);
        rst = 0;
        step();
        chk("idle_so_sh", {so0, sh0, so1, sh1}, 0);

        slot(1000, 2'b01, 0, 0); slot(2000, 2'b11, 0, 0); slot(-500, 2'b10, 1, 0);
        chk("mix_pcm0", pcm0, {16'd1500, 16'd3000});
        chk("mix_pcm1", pcm1, {16'd1500, 16'd3000});
        chk("mix_valid", {vld0, vld1}, 2'b11);
        capture(2, -1, 0);
        chk("valid_pulse", v_after, 0);
        chk_words("mix", 2, '{16'h1377, 16'h0F77, 0, 0}, '{16'd3000, 16'd1500, 0, 0});
        step();
        chk("end_idle", {so0, sh0, so1, sh1}, 0);

        frame(8191, 2'b01, 4, 0);
        chk("edge_pos_pcm", pcm0, {16'd0, 16'd32764});
        chk("edge_pos_sat", sat0, 2'b00);
        repeat (40) step();
        frame(8191, 2'b01, 5, 0);
        chk("clamp_pos_pcm", pcm0, {16'd0, 16'h7fff});
        chk("clamp_pos_sat", sat0, 2'b01);
        repeat (40) step();
        chk("sat_sticky", sat0, 2'b01);
        frame(-8192, 2'b10, 4, 0);
        chk("edge_neg_pcm", pcm0, {16'h8000, 16'd0});
        chk("edge_neg_sat", sat0, 2'b01);
        repeat (40) step();
        frame(-8192, 2'b10, 5, 0);
        chk("clamp_neg_pcm", pcm1, {16'h8000, 16'd0});
        chk("clamp_neg_sat", sat1, 2'b11);
        repeat (40) step();
        frame(8191, 2'b01, 5, 1);
        chk("set_wins", sat0, 2'b01);
        clr = 1; step(); clr = 0;
        chk("sat_clr", {sat0, sat1}, 0);
        repeat (40) step();

        slot(256, 2'b01, 1, 0);
        capture(2, -1, 0);
        chk_words("f256", 2, '{16'h0700, 16'h0600, 0, 0}, '{16'h0100, 16'h0000, 0, 0});
        slot(-2, 2'b11, 1, 0);
        capture(2, -1, 0);
        chk_words("neg2", 2, '{16'h05FE, 16'h05FE, 0, 0}, '{16'hFFFE, 16'hFFFE, 0, 0});
        chk("no_ovr_yet", {ovr0, ovr1}, 0);

        slot(100, 2'b11, 1, 0);
        capture(4, 9, 200);
        chk("ovr", {ovr0, ovr1}, 2'b11);
        chk("ovr_pcm", pcm1, {16'd200, 16'd200});
        chk_words("ovr", 4, '{16'h0664, 16'h0664, 16'h06C8, 16'h06C8}, '{16'd100, 16'd100, 16'd200, 16'd200});
        step();
        chk("ovr_idle", {so0, sh0, so1, sh1}, 0);

        slot(300, 2'b01, 1, 0);
        step(); step(); step();
        chk("pre_stall", {so0, sh0, so1, sh1}, 4'b1010);
        ncen = 1; valid = 1; data = 77; mask = 2'b11; fe = 1;
        repeat (5) step();
        chk("stall_so", {so0, sh0, so1, sh1}, 4'b1010);
        chk("stall_pcm", pcm0, {16'd0, 16'd300});
        chk("stall_valid", {vld0, vld1}, 0);
        ncen = 0; valid = 0; data = 0; mask = 0; fe = 0;
        step();
        chk("post_stall", {so0, sh0, so1, sh1}, 4'b1010);
        rst = 1; step(); rst = 0;
        chk("mid_rst_pcm", pcm0 | pcm1, 0);
        chk("mid_rst_out", {vld0, so0, sh0, sat0, ovr0, vld1, so1, sh1, sat1, ovr1}, 0);
        any_sh = 0;
        repeat (20) begin step(); any_sh |= sh0 | sh1 | so0 | so1; end
        chk("no_sh_after_rst", any_sh, 0);
        slot(5, 2'b01, 1, 0);
        capture(2, -1, 0);
        chk_words("resume", 2, '{16'h0605, 16'h0600, 0, 0}, '{16'd5, 16'd0, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
